// File: rtl/clk_en_sched_pkg.sv
// Shared constants for the clock-enable scheduler: widths, reset ratio, state codes.
package clk_en_sched_pkg;

   localparam int unsigned CNT_W       = 26;
   localparam int unsigned NCNT_W      = 8;
   localparam int unsigned DEFAULT_DIV = 25_000_000;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/clk_en_sched_div_counter.sv
// Divide counter: holds the active ratio and counts 0..div-1, flagging the terminal count.
module div_counter
   import clk_en_sched_pkg::*;
#(
   parameter int unsigned CNT_W       = clk_en_sched_pkg::CNT_W,
   parameter int unsigned DEFAULT_DIV = clk_en_sched_pkg::DEFAULT_DIV
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             clear,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_div,
   output logic             tc_c
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_r;

   // Terminal count only matters while counting; div_r is never 0, so div_r-1 never wraps.
   assign tc_c = en && (cnt == (div_r - CNT_W'(1)));

   // Ratio latch and count register; clear has priority over counting.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         cnt   <= '0;
         div_r <= CNT_W'(DEFAULT_DIV);
      end else begin
         if (load) begin
            div_r <= load_div;
         end
         if (clear) begin
            cnt <= '0;
         end else if (en) begin
            cnt <= tc_c ? '0 : cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/clk_en_sched.sv
// Clock-enable scheduler: config handshake, run/hold/stop sequencing, one-shot tick budget,
// and registered tick / clk_out / busy / done outputs.
module clk_en_sched
   import clk_en_sched_pkg::*;
#(
   parameter int unsigned CNT_W       = clk_en_sched_pkg::CNT_W,
   parameter int unsigned DEFAULT_DIV = clk_en_sched_pkg::DEFAULT_DIV,
   parameter int unsigned NCNT_W      = clk_en_sched_pkg::NCNT_W
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_mode,
   input  logic [NCNT_W-1:0] cfg_count,
   input  logic              start,
   input  logic              stop,
   input  logic              hold,
   output logic              tick,
   output logic              clk_out,
   output logic              busy,
   output logic              done
);

   logic [1:0]        state;
   logic [1:0]        state_nx;
   logic              mode_r;
   logic [NCNT_W-1:0] cnt_r;
   logic [NCNT_W-1:0] rem;
   logic [NCNT_W-1:0] rem_nx;
   logic              tick_nx;
   logic              clk_out_nx;

   logic              cfg_fire_c;
   logic              mode_eff_c;
   logic [NCNT_W-1:0] count_eff_c;
   logic [CNT_W-1:0]  div_eff_c;
   logic              active_c;
   logic              cnt_en_c;
   logic              cnt_clear_c;
   logic              tc_c;

   // Config is taken only in IDLE and never while reset is asserted.
   assign cfg_ready   = (state == ST_IDLE) && clr_n;
   assign cfg_fire_c  = cfg_valid && cfg_ready;
   // A zero ratio would make div-1 wrap, so it runs as divide-by-one.
   assign div_eff_c   = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
   // A config arriving with start takes effect for that start.
   assign mode_eff_c  = cfg_fire_c ? cfg_mode : mode_r;
   assign count_eff_c = cfg_fire_c ? cfg_count : cnt_r;

   assign active_c    = (state == ST_RUN) || (state == ST_HOLD);
   assign cnt_en_c    = active_c && !hold && !stop;
   assign cnt_clear_c = ((state == ST_IDLE) && start && !stop) || (active_c && stop);

   div_counter #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_div (
      .clk      (clk),
      .clr_n    (clr_n),
      .clear    (cnt_clear_c),
      .en       (cnt_en_c),
      .load     (cfg_fire_c),
      .load_div (div_eff_c),
      .tc_c     (tc_c)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_nx   = state;
      rem_nx     = rem;
      tick_nx    = 1'b0;
      clk_out_nx = clk_out;
      case (state)
         ST_IDLE: begin
            if (start && !stop) begin
               rem_nx   = count_eff_c;
               state_nx = (mode_eff_c && (count_eff_c == '0)) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN, ST_HOLD: begin
            if (stop) begin
               state_nx   = ST_IDLE;
               clk_out_nx = 1'b0;
            end else if (hold) begin
               state_nx = ST_HOLD;
            end else begin
               state_nx = ST_RUN;
               if (tc_c) begin
                  tick_nx    = 1'b1;
                  clk_out_nx = ~clk_out;
                  if (mode_r) begin
                     rem_nx = rem - NCNT_W'(1);
                     if (rem == NCNT_W'(1)) begin
                        state_nx = ST_DONE;
                     end
                  end
               end
            end
         end
         ST_DONE: begin
            state_nx   = ST_IDLE;
            clk_out_nx = 1'b0;
         end
         default: begin
            state_nx   = ST_IDLE;
            clk_out_nx = 1'b0;
         end
      endcase
   end

   // State, config and output registers.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state   <= ST_IDLE;
         mode_r  <= 1'b0;
         cnt_r   <= '0;
         rem     <= '0;
         tick    <= 1'b0;
         clk_out <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nx;
         rem     <= rem_nx;
         tick    <= tick_nx;
         clk_out <= clk_out_nx;
         busy    <= (state_nx == ST_RUN) || (state_nx == ST_HOLD);
         done    <= (state_nx == ST_DONE);
         if (cfg_fire_c) begin
            mode_r <= cfg_mode;
            cnt_r  <= cfg_count;
         end
      end
   end

endmodule

// File: tb/tb_clk_en_sched.sv
// Scoreboard bench for clk_en_sched: stimulus queues expected tick/done times and status
// probes; a monitor pops and compares on every falling edge.
module tb_clk_en_sched;

   localparam int unsigned CW = 26;
   localparam int unsigned NW = 8;

   typedef struct {
      int   t;
      logic busy;
      logic clk_o;
      logic rdy;
   } probe_t;

   logic          clk = 1'b0;
   logic          clr_n;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [CW-1:0] cfg_div;
   logic          cfg_mode;
   logic [NW-1:0] cfg_count;
   logic          start;
   logic          stop;
   logic          hold;
   logic          tick;
   logic          clk_out;
   logic          busy;
   logic          done;

   int     cyc = 0;
   int     tq[$];
   int     dq[$];
   probe_t pq[$];
   int     checks = 0;
   int     errors = 0;
   bit     fin = 1'b0;
   int     s;

   clk_en_sched #(
      .CNT_W       (CW),
      .DEFAULT_DIV (6),
      .NCNT_W      (NW)
   ) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_div   (cfg_div),
      .cfg_mode  (cfg_mode),
      .cfg_count (cfg_count),
      .start     (start),
      .stop      (stop),
      .hold      (hold),
      .tick      (tick),
      .clk_out   (clk_out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Rising-edge counter used as the time base for all expectations.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic at(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic cfg(input int d, input bit m, input int n);
      cfg_valid = 1'b1;
      cfg_div   = CW'(d);
      cfg_mode  = m;
      cfg_count = NW'(n);
   endtask

   task automatic probe(input int t, input bit b, input bit c, input bit r);
      probe_t p;
      p.t = t; p.busy = b; p.clk_o = c; p.rdy = r;
      pq.push_back(p);
   endtask

   // Stimulus: directed scenarios with hand-computed event times.
   initial begin
      clr_n = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_mode = 1'b0; cfg_count = '0;
      start = 1'b0; stop = 1'b0; hold = 1'b0;
      at(2);
      probe(3, 0, 0, 0);
      at(4); clr_n = 1'b1;
      probe(5, 0, 0, 1);

      // continuous, divide by 4
      at(6); s = cyc; cfg(4, 0, 0);
      tq.push_back(s+6); tq.push_back(s+10); tq.push_back(s+14);
      probe(s+3, 1, 0, 0); probe(s+6, 1, 1, 0); probe(s+10, 1, 0, 0);
      probe(s+14, 1, 1, 0); probe(s+17, 0, 0, 1);
      at(s+1); cfg_valid = 1'b0; start = 1'b1;
      at(s+2); start = 1'b0;
      at(s+15); stop = 1'b1;
      at(s+16); stop = 1'b0;

      // one-shot, divide by 2, three ticks; config together with start
      at(s+18); s = cyc; cfg(2, 1, 3); start = 1'b1;
      tq.push_back(s+3); tq.push_back(s+5); tq.push_back(s+7); dq.push_back(s+7);
      probe(s+4, 1, 1, 0); probe(s+7, 0, 1, 0); probe(s+8, 0, 0, 1);
      at(s+1); cfg_valid = 1'b0; start = 1'b0;

      // divide by 0 coerced to 1
      at(s+10); s = cyc; cfg(0, 0, 0); start = 1'b1;
      for (int i = 2; i <= 5; i++) tq.push_back(s+i);
      probe(s+4, 1, 1, 0); probe(s+7, 0, 0, 1);
      at(s+1); cfg_valid = 1'b0; start = 1'b0;
      at(s+5); stop = 1'b1;
      at(s+6); stop = 1'b0;

      // divide by 1
      at(s+9); s = cyc; cfg(1, 0, 0); start = 1'b1;
      for (int i = 2; i <= 4; i++) tq.push_back(s+i);
      probe(s+6, 0, 0, 1);
      at(s+1); cfg_valid = 1'b0; start = 1'b0;
      at(s+4); stop = 1'b1;
      at(s+5); stop = 1'b0;

      // one-shot with zero count: done only
      at(s+8); s = cyc; cfg(3, 1, 0); start = 1'b1;
      dq.push_back(s+1);
      probe(s+1, 0, 0, 0); probe(s+2, 0, 0, 1);
      at(s+1); cfg_valid = 1'b0; start = 1'b0;

      // hold for 5 cycles at cnt=2, then stop on a terminal count
      at(s+4); s = cyc; cfg(4, 0, 0); start = 1'b1;
      tq.push_back(s+10);
      probe(s+6, 1, 0, 0); probe(s+12, 1, 1, 0); probe(s+15, 0, 0, 1);
      at(s+1); cfg_valid = 1'b0; start = 1'b0;
      at(s+3); hold = 1'b1;
      at(s+8); hold = 1'b0;
      at(s+13); stop = 1'b1;
      at(s+14); stop = 1'b0;

      // config held during RUN, accepted after stop; start+stop in IDLE
      at(s+17); s = cyc; cfg(4, 0, 0); start = 1'b1;
      tq.push_back(s+5); tq.push_back(s+9); tq.push_back(s+25);
      probe(s+3, 1, 0, 0); probe(s+6, 1, 1, 0); probe(s+14, 0, 0, 1); probe(s+28, 0, 0, 1);
      at(s+1); cfg_valid = 1'b0; start = 1'b0;
      at(s+2); cfg(10, 0, 0);
      at(s+10); stop = 1'b1;
      at(s+11); stop = 1'b0;
      at(s+12); cfg_valid = 1'b0; start = 1'b1; stop = 1'b1;
      at(s+13); start = 1'b0; stop = 1'b0;
      at(s+14); start = 1'b1;
      at(s+15); start = 1'b0;
      at(s+26); stop = 1'b1;
      at(s+27); stop = 1'b0;

      // reset mid one-shot, then restart on the default ratio (6)
      at(s+30); s = cyc; cfg(3, 1, 5); start = 1'b1;
      tq.push_back(s+4); tq.push_back(s+7); tq.push_back(s+17);
      probe(s+10, 0, 0, 1); probe(s+13, 1, 0, 0); probe(s+19, 0, 0, 1);
      at(s+1); cfg_valid = 1'b0; start = 1'b0;
      at(s+8); clr_n = 1'b0;
      at(s+9); clr_n = 1'b1;
      at(s+10); start = 1'b1;
      at(s+11); start = 1'b0;
      at(s+17); stop = 1'b1;
      at(s+18); stop = 1'b0;

      at(s+24); fin = 1'b1;
   end

   // Monitor: compare tick/done events and status probes against the queues.
   initial begin
      while (!fin) begin
         @(negedge clk);
         while (tq.size() > 0 && tq[0] < cyc) begin
            checks++; errors++;
            $display("FAIL tick_missed at cycle %0d required at %0d", cyc, tq[0]);
            void'(tq.pop_front());
         end
         if (tick === 1'b1) begin
            checks++;
            if (tq.size() > 0 && tq[0] == cyc) begin
               void'(tq.pop_front());
            end else begin
               errors++;
               $display("FAIL tick_unexpected at cycle %0d next required %0d", cyc,
                        (tq.size() > 0) ? tq[0] : -1);
            end
         end
         while (dq.size() > 0 && dq[0] < cyc) begin
            checks++; errors++;
            $display("FAIL done_missed at cycle %0d required at %0d", cyc, dq[0]);
            void'(dq.pop_front());
         end
         if (done === 1'b1) begin
            checks++;
            if (dq.size() > 0 && dq[0] == cyc) begin
               void'(dq.pop_front());
            end else begin
               errors++;
               $display("FAIL done_unexpected at cycle %0d next required %0d", cyc,
                        (dq.size() > 0) ? dq[0] : -1);
            end
         end
         while (pq.size() > 0 && pq[0].t <= cyc) begin
            checks++;
            if (busy !== pq[0].busy || clk_out !== pq[0].clk_o || cfg_ready !== pq[0].rdy) begin
               errors++;
               $display("FAIL status at cycle %0d busy/clk_out/cfg_ready got %b%b%b required %b%b%b",
                        cyc, busy, clk_out, cfg_ready, pq[0].busy, pq[0].clk_o, pq[0].rdy);
            end
            void'(pq.pop_front());
         end
      end
      while (tq.size() > 0) begin
         checks++; errors++;
         $display("FAIL tick_never_seen required at %0d", tq[0]);
         void'(tq.pop_front());
      end
      while (dq.size() > 0) begin
         checks++; errors++;
         $display("FAIL done_never_seen required at %0d", dq[0]);
         void'(dq.pop_front());
      end
      while (pq.size() > 0) begin
         checks++; errors++;
         $display("FAIL status_never_checked required at %0d", pq[0].t);
         void'(pq.pop_front());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_en_sched.md
Name: clk_en_sched

Overview:
Programmable clock-enable scheduler that owns and sequences the board's frequency-divider resource. It accepts a divide ratio via a valid/ready config handshake and runs the divider on start/stop commands. It emits a one-cycle tick enable plus a square-wave clk_out, in either continuous mode or one-shot mode (N ticks, then done). Downstream lab blocks such as counters and displays consume tick as a clock enable instead of a derived clock.

Parameters:
CNT_W, 26, width of the divide counter and of cfg_div
DEFAULT_DIV, 25_000_000, divide ratio after reset; 50 MHz clk with clk_out toggling per tick gives 1 Hz
NCNT_W, 8, width of the one-shot tick count

Ports:
clk  input  1  system clock, 50 MHz; all logic on posedge
clr_n  input  1  synchronous active-low reset, sampled on posedge clk
cfg_valid  input  1  config request
cfg_ready  output  1  config accepted when cfg_valid && cfg_ready; equals (state==IDLE) && clr_n
cfg_div  input  CNT_W  divide ratio D; tick every D clk cycles
cfg_mode  input  1  0 = continuous, 1 = one-shot
cfg_count  input  NCNT_W  number of ticks in one-shot mode
start  input  1  begin running (honoured in IDLE only)
stop  input  1  abort (honoured in RUN/HOLD)
hold  input  1  freeze divide counter while high (RUN only)
tick  output  1  registered one-cycle enable pulse
clk_out  output  1  registered square wave, toggles on every tick
busy  output  1  high in RUN or HOLD
done  output  1  one-cycle pulse on one-shot completion

Behaviour:
- Reset (clr_n=0 at posedge):
  - state=IDLE, cnt=0, div_r=DEFAULT_DIV, mode_r=0, rem=0.
  - Outputs: tick=0, clk_out=0, busy=0, done=0.
  - Reset mid-run aborts immediately; no done pulse.
- States: IDLE, RUN, HOLD, DONE.
- IDLE:
  - Config handshake: latches div_r=cfg_div, mode_r, cnt_r=cfg_count. cfg_div==0 is coerced to 1.
  - start and stop in the same cycle: stop wins, stay IDLE.
  - start alone: state->RUN, cnt->0, rem->cnt_r.
  - One-shot with cnt_r==0: start goes IDLE->DONE directly (done pulse, no ticks).
  - Config and start in the same cycle: the new config is used.
- RUN:
  - cnt increments each cycle.
  - When cnt==div_r-1: cnt->0, tick->1 for the next cycle, clk_out toggles.
  - First tick is high D cycles after entering RUN, then every D cycles. D=1 gives tick constantly high and clk_out toggling every cycle.
  - One-shot: rem decrements on each terminal count. The terminal count that brings rem to 0 goes to DONE; that final tick still fires.
  - hold=1: RUN->HOLD, cnt frozen, no tick, clk_out held.
  - hold=0 in HOLD: return to RUN and resume from the frozen cnt.
- stop in RUN or HOLD:
  - Next state IDLE; suppresses any tick in that cycle; clk_out->0, cnt->0.
  - stop beats a simultaneous terminal count and a simultaneous hold.
- DONE: lasts one cycle with done=1; clk_out->0; then IDLE.
- busy is registered and high exactly while state is RUN or HOLD.
- Config arriving outside IDLE is not accepted (cfg_ready=0); the requester holds cfg_valid.
- Width: cnt is CNT_W bits unsigned; the comparison uses div_r-1 and never wraps because div_r>=1.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, RUN=2'd1, HOLD=2'd2, DONE=2'd3), DEFAULT_DIV, CNT_W.
- One sub-module, div_counter: cnt register with clear, enable and load-ratio inputs; outputs terminal-count.
- The FSM, handshake, rem counter and output registers stay in clk_en_sched.

Test Plan:
- Continuous, reset then cfg_div=4, start: tick high in cycles 4, 8, 12 after RUN entry; clk_out period 8 cycles; busy=1.
- One-shot, cfg_div=2, cfg_count=3, start: exactly 3 ticks, 2 cycles apart; done pulses the cycle after the 3rd terminal count; busy drops; cfg_ready returns to 1.
- Corner cases, cfg_div=0 and cfg_div=1: tick high every cycle after start. One-shot cfg_count=0: done pulse one cycle after start, zero ticks.
- hold high for 5 cycles mid-period (cfg_div=4, at cnt=2): the next tick is delayed by exactly 5 cycles. Then stop coincident with a terminal count: no tick, IDLE, clk_out=0.
- cfg_valid with cfg_div=10 during RUN: not accepted; period stays 4 until stop, then accepted in IDLE. start and stop together in IDLE: stays IDLE.
- clr_n low for 1 cycle mid one-shot: all outputs 0, div_r=DEFAULT_DIV, no done pulse, state IDLE.
